// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: debounce FSM states, per-frame scan result
// and the key-code width helper.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_e;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_kind_e;

  function automatic int code_width(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row driver and column sampler: synchronises the columns, dwells on each row, and
// classifies every full scan frame as NONE, SINGLE(code) or MULTI.
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int CW       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] key_col_i,
  output logic [ROWS-1:0] key_row_o,
  output logic            frame_done_o,
  output frame_kind_e     frame_kind_o,
  output logic [CW-1:0]   frame_code_o
);

  localparam int RIW = $clog2(ROWS);
  localparam int DVW = $clog2(SCAN_DIV);

  logic [COLS-1:0] col_s1_q, col_s2_q;
  logic [DVW-1:0]  dwell_q;
  logic [RIW-1:0]  row_q;
  logic [1:0]      acc_n_q;
  logic [CW-1:0]   acc_code_q;

  logic            tc, last_row;
  logic [1:0]      row_n, tot_n;
  logic [2:0]      sum_n;
  logic [CW-1:0]   row_code;

  assign tc           = (dwell_q == DVW'(SCAN_DIV - 1));
  assign last_row     = (row_q == RIW'(ROWS - 1));
  assign key_row_o    = ~(ROWS'(1) << row_q);
  assign frame_done_o = tc && last_row;

  // Active-key count saturates at 2: only "none / one / more" matters.
  always_comb begin
    row_n    = 2'd0;
    row_code = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_s2_q[c]) begin
        if (row_n != 2'd2) row_n = row_n + 2'd1;
        row_code = CW'(int'(row_q) * COLS + c);
      end
    end
    sum_n        = {1'b0, acc_n_q} + {1'b0, row_n};
    tot_n        = (sum_n > 3'd2) ? 2'd2 : sum_n[1:0];
    frame_code_o = (acc_n_q != 2'd0) ? acc_code_q : row_code;
    case (tot_n)
      2'd0:    frame_kind_o = NONE;
      2'd1:    frame_kind_o = SINGLE;
      default: frame_kind_o = MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_s1_q   <= '1;
      col_s2_q   <= '1;
      dwell_q    <= '0;
      row_q      <= '0;
      acc_n_q    <= '0;
      acc_code_q <= '0;
    end else begin
      col_s1_q <= key_col_i;
      col_s2_q <= col_s1_q;
      if (tc) begin
        dwell_q <= '0;
        if (last_row) begin
          row_q      <= '0;
          acc_n_q    <= '0;
          acc_code_q <= '0;
        end else begin
          row_q      <= row_q + RIW'(1);
          acc_n_q    <= tot_n;
          acc_code_q <= frame_code_o;
        end
      end else begin
        dwell_q <= dwell_q + DVW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner top: frame-level debounce FSM and output registers.
// Optional auto-repeat is built when KEYPAD_REPEAT_EN is defined.
//
//  state    | meaning
//  IDLE     | no key accepted, waiting for a single key
//  DEBOUNCE | counting identical single-key frames for a candidate
//  PRESSED  | key accepted, key_held high, rollover locked
//  RELEASE  | counting empty frames before dropping key_held
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10,
  localparam int CW             = code_width(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] key_col,
  output logic [ROWS-1:0] key_row,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic            multi_key
);

  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DF  = DW'(DEBOUNCE_FRAMES);
  localparam logic [DW-1:0] ONE = DW'(1);

  logic          frame_done;
  frame_kind_e   frame_kind;
  logic [CW-1:0] frame_code;

  kp_state_e     state_q, state_d;
  logic [CW-1:0] cand_q, cand_d, code_q, code_d, acc_code;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d, held_q, held_d, multi_q, multi_d;
  logic          accept, rep_fire;

  keypad_row_scan #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .CW(CW)
  ) u_scan (
    .clk(clk), .reset(reset), .key_col_i(key_col), .key_row_o(key_row),
    .frame_done_o(frame_done), .frame_kind_o(frame_kind), .frame_code_o(frame_code)
  );

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    held_d   = held_q;
    multi_d  = multi_q;
    valid_d  = 1'b0;
    accept   = 1'b0;
    acc_code = frame_code;
    if (frame_done) begin
      multi_d = (frame_kind == MULTI);
      case (state_q)
        IDLE: begin
          if (frame_kind == SINGLE) begin
            if (DEBOUNCE_FRAMES == 1) accept = 1'b1;
            else begin
              state_d = DEBOUNCE;
              cand_d  = frame_code;
              cnt_d   = ONE;
            end
          end
        end
        DEBOUNCE: begin
          if (frame_kind == SINGLE && frame_code == cand_q) begin
            if (cnt_q + ONE == DF) begin
              accept   = 1'b1;
              acc_code = cand_q;
            end else cnt_d = cnt_q + ONE;
          end else if (frame_kind == SINGLE) begin
            cand_d = frame_code;
            cnt_d  = ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (!((frame_kind == SINGLE && frame_code == code_q) || frame_kind == MULTI)) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = IDLE;
              held_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE;
              cnt_d   = ONE;
            end
          end
        end
        RELEASE: begin
          if (frame_kind == NONE) begin
            if (cnt_q + ONE == DF) begin
              state_d = IDLE;
              held_d  = 1'b0;
              cnt_d   = '0;
            end else cnt_d = cnt_q + ONE;
          end else if (frame_kind == SINGLE && frame_code == code_q) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else cnt_d = ONE;
        end
        default: state_d = IDLE;
      endcase
      if (accept) begin
        state_d = PRESSED;
        code_d  = acc_code;
        valid_d = 1'b1;
        held_d  = 1'b1;
        cnt_d   = '0;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_next;
  logic          rep_started_q, rep_started_d;

  // Counter only advances on frames where the FSM stays in PRESSED; any entry resets it.
  always_comb begin
    rep_cnt_d     = rep_cnt_q;
    rep_started_d = rep_started_q;
    rep_fire      = 1'b0;
    rep_next      = rep_cnt_q + RW'(1);
    if (state_q != PRESSED || state_d != PRESSED) begin
      rep_cnt_d     = '0;
      rep_started_d = 1'b0;
    end else if (frame_done) begin
      if ((!rep_started_q && rep_next == RW'(REPEAT_DELAY)) ||
          (rep_started_q && rep_next == RW'(REPEAT_RATE))) begin
        rep_fire      = 1'b1;
        rep_cnt_d     = '0;
        rep_started_d = 1'b1;
      end else rep_cnt_d = rep_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt_q     <= '0;
      rep_started_q <= 1'b0;
    end else begin
      rep_cnt_q     <= rep_cnt_d;
      rep_started_q <= rep_started_d;
    end
  end
`else
  assign rep_fire = 1'b0;
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_params_unused
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d | rep_fire;
      held_q  <= held_d;
      multi_q <= multi_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed keypad scenarios plus randomized
// frame sequences against a frame-level reference model (KEYPAD_REPEAT_EN aware).
module tb_keypad_scanner;

  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DF = 3;
  localparam int RDELAY = 5, RRATE = 2;
  localparam int FRAME = ROWS * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [COLS-1:0] key_col;
  logic [ROWS-1:0] key_row;
  logic [3:0]      key_code;
  logic            key_valid, key_held, multi_key;
  logic [15:0]     keys;

  int n_checks = 0, n_pass = 0;

  // Reference model: held key, release phase, run length of identical frames, repeat age.
  int m_held, m_rel, m_run, m_cand, m_code, m_rep, m_multi, exp_pulse;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF),
    .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
  ) dut (
    .clk(clk), .reset(reset), .key_col(key_col), .key_row(key_row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
  );

  // A pressed switch shorts its row line to its column line.
  always_comb begin
    key_col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (key_row[r] == 1'b0 && keys[r*COLS+c]) key_col[c] = 1'b0;
  end

  task automatic model_reset;
    m_held = 0; m_rel = 0; m_run = 0; m_cand = 0; m_code = 0; m_rep = 0; m_multi = 0;
  endtask

  task automatic model_step(input logic [15:0] ks);
    int n, code;
    n = 0; code = 0;
    for (int k = 0; k < 16; k++) if (ks[k]) begin n++; code = k; end
    exp_pulse = 0;
    m_multi = (n > 1);
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && code == m_cand) m_run++;
        else begin m_cand = code; m_run = 1; end
        if (m_run == DF) begin
          m_held = 1; m_rel = 0; m_code = code; m_run = 0; m_rep = 0; exp_pulse = 1;
        end
      end else m_run = 0;
    end else if (!m_rel) begin
      if ((n == 1 && code == m_code) || n > 1) begin
        m_rep++;
        if (REP && (m_rep == RDELAY || (m_rep > RDELAY && (m_rep - RDELAY) % RRATE == 0)))
          exp_pulse = 1;
      end else begin
        m_rel = 1; m_run = 1; m_rep = 0;
      end
    end else begin
      if (n == 0) begin
        m_run++;
        if (m_run == DF) begin m_held = 0; m_rel = 0; m_run = 0; end
      end else if (n == 1 && code == m_code) begin
        m_rel = 0; m_run = 0; m_rep = 0;
      end else m_run = 1;
    end
  endtask

  // Called at a frame-start falling edge; returns at the next one, where this frame's pulse is visible.
  task automatic do_frame(input logic [15:0] ks, output int pulses);
    keys = ks;
    pulses = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (key_valid === 1'b1) pulses++;
    end
    model_step(ks);
  endtask

  task automatic test_reset;
    logic [ROWS-1:0] exp_row;
    reset = 1'b0;
    keys = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({key_row, key_code, key_valid, key_held, multi_key} !== {4'b1110, 4'd0, 3'b000}) begin
      $display("FAIL reset_state: got row=%b code=%0d v=%b h=%b m=%b, want row=1110 code=0 v=0 h=0 m=0",
               key_row, key_code, key_valid, key_held, multi_key);
    end else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      exp_row = ~(4'b0001 << ((i / SCAN_DIV) % ROWS));
      n_checks++;
      if ({key_row, key_code, key_valid, key_held, multi_key} !== {exp_row, 4'd0, 3'b000}) begin
        $display("FAIL row_rotation[%0d]: got row=%b code=%0d v=%b h=%b m=%b, want row=%b others 0",
                 i, key_row, key_code, key_valid, key_held, multi_key, exp_row);
      end else n_pass++;
      @(negedge clk);
    end
    for (int f = 0; f < 2; f++) model_step('0);
  endtask

  task automatic test_single_press;
    int p;
    for (int f = 1; f <= 5; f++) begin
      do_frame(16'h0040, p);
      n_checks++;
      if (p !== ((f == 3) ? 1 : 0) || key_held !== (f >= 3)) begin
        $display("FAIL single_press frame %0d: got pulses=%0d held=%b, want pulses=%0d held=%b",
                 f, p, key_held, (f == 3) ? 1 : 0, f >= 3);
      end else n_pass++;
    end
    n_checks++;
    if (key_code !== 4'd6 || key_held !== 1'b1 || multi_key !== 1'b0) begin
      $display("FAIL single_press_code: got code=%0d held=%b multi=%b, want code=6 held=1 multi=0",
               key_code, key_held, multi_key);
    end else n_pass++;
  endtask

  task automatic test_release_bounce;
    int p, total;
    total = 0;
    do_frame(16'h0000, p); total += p;
    do_frame(16'h0040, p); total += p;
    do_frame(16'h0040, p); total += p;
    n_checks++;
    if (total !== 0 || key_held !== 1'b1) begin
      $display("FAIL release_bounce: got pulses=%0d held=%b, want pulses=0 held=1", total, key_held);
    end else n_pass++;
    for (int f = 1; f <= 3; f++) begin
      do_frame(16'h0000, p);
      n_checks++;
      if (p !== 0 || key_held !== (f < 3)) begin
        $display("FAIL release frame %0d: got pulses=%0d held=%b, want pulses=0 held=%b",
                 f, p, key_held, f < 3);
      end else n_pass++;
    end
  endtask

  task automatic test_bounce_reject;
    int p, total;
    total = 0;
    for (int f = 0; f < 8; f++) begin
      do_frame((f % 2 == 0) ? 16'h8000 : 16'h0000, p);
      total += p;
      n_checks++;
      if (key_held !== 1'b0) begin
        $display("FAIL bounce_held frame %0d: got held=%b, want 0", f, key_held);
      end else n_pass++;
    end
    n_checks++;
    if (total !== 0 || key_code !== 4'd6) begin
      $display("FAIL bounce_reject: got pulses=%0d code=%0d, want pulses=0 code=6", total, key_code);
    end else n_pass++;
  endtask

  task automatic test_multi_key;
    int p;
    do_frame(16'h0801, p);
    n_checks++;
    if (multi_key !== 1'b1 || p !== 0 || key_held !== 1'b0) begin
      $display("FAIL multi_detect: got multi=%b pulses=%0d held=%b, want multi=1 pulses=0 held=0",
               multi_key, p, key_held);
    end else n_pass++;
    do_frame(16'h0801, p);
    do_frame(16'h0000, p);
    n_checks++;
    if (multi_key !== 1'b0 || p !== 0) begin
      $display("FAIL multi_clear: got multi=%b pulses=%0d, want multi=0 pulses=0", multi_key, p);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_debounce;
    int p, total;
    bit want;
    do_frame(16'h0020, p);
    do_frame(16'h0020, p);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({key_row, key_code, key_valid, key_held, multi_key} !== {4'b1110, 4'd0, 3'b000}) begin
      $display("FAIL midreset_state: got row=%b code=%0d v=%b h=%b m=%b, want row=1110 code=0 v=0 h=0 m=0",
               key_row, key_code, key_valid, key_held, multi_key);
    end else n_pass++;
    model_reset();
    reset = 1'b1;
    total = 0;
    for (int f = 1; f <= 12; f++) begin
      do_frame(16'h0020, p);
      total += p;
      want = (f == 3) || (REP && (f == 8 || f == 10 || f == 12));
      n_checks++;
      if (p !== int'(want)) begin
        $display("FAIL midreset_pulse frame %0d: got pulses=%0d, want %0d", f, p, want);
      end else n_pass++;
    end
    n_checks++;
    if (total !== (REP ? 4 : 1) || key_code !== 4'd5 || key_held !== 1'b1) begin
      $display("FAIL midreset_final: got pulses=%0d code=%0d held=%b, want pulses=%0d code=5 held=1",
               total, key_code, key_held, REP ? 4 : 1);
    end else n_pass++;
  endtask

  task automatic test_random;
    logic [15:0] ks;
    int p, sel;
    ks = 16'h0020;
    for (int f = 0; f < 80; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 7) ks = '0;
      else if (sel == 8) ks = 16'h1 << $urandom_range(0, 15);
      else if (sel == 9) ks = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      do_frame(ks, p);
      n_checks++;
      if (p !== exp_pulse || key_held !== (m_held != 0) || key_code !== m_code[3:0] ||
          multi_key !== (m_multi != 0)) begin
        $display("FAIL random frame %0d keys=%h: got p=%0d h=%b c=%0d m=%b, want p=%0d h=%0d c=%0d m=%0d",
                 f, ks, p, key_held, key_code, multi_key, exp_pulse, m_held, m_code, m_multi);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release_bounce();
    test_bounce_reject();
    test_multi_key();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
